demux8_reg: RTL and testbench
=============================

DEMUX8_REG -- requirements
Module: demux8_reg

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- D  input  32  write data.
- F  input  3  destination select, 0..7.
- En  input  1  write request; sampled each rising edge.
- Clr  input  1  start clear sweep; sampled each rising edge.
- Ack  output  1  write-accepted pulse.
- Busy  output  1  clear sweep in progress.
- N0..N7  output  32 each  registered destination words, driven directly from state.
REQ-002 The block SHALL have one parameter: WIDTH, default 32, data width of D and N0..N7.

Function
REQ-003 The block SHALL be a registered 1-to-8 demultiplexer: the write-side counterpart of the 8:1 select path that reads N0..N7.
REQ-004 The FSM SHALL have two states: IDLE and CLEAR.
REQ-005 IDLE with En=1 and Clr=0 SHALL load D into N[F] at that edge; all other Nk SHALL hold.
REQ-006 An accepted write SHALL assert Ack for exactly one cycle, in the cycle after the accepting edge; the new N[F] value SHALL be visible in that same cycle.
REQ-007 Back-to-back writes SHALL be accepted every cycle, with no bubbles; Ack SHALL stay high while writes keep being accepted.
REQ-008 IDLE with Clr=1 SHALL enter CLEAR and load the 3-bit sweep counter with 0. Clr SHALL win over a simultaneous En: the write is dropped and no Ack is issued.
REQ-009 In CLEAR, each edge SHALL zero N[counter] and increment the counter. The edge at counter=7 SHALL return to IDLE; the counter wraps to 0 and is not reused.
REQ-010 Busy SHALL be high exactly in the 8 cycles the FSM is in CLEAR, starting the cycle after Clr is sampled.
REQ-011 In CLEAR, En and Clr SHALL be ignored: no write, no Ack, no restart. Data presented is lost; the requester must retry when Busy=0.
REQ-012 An F value outside 0..7 is impossible by width; no error handling SHALL exist.
REQ-013 Ack, Busy and N0..N7 SHALL all be registered outputs, with no combinational path from inputs.

Reset
REQ-014 rst=1 at a rising edge SHALL force N0..N7=0, Ack=0, Busy=0, state=IDLE and counter=0.
REQ-015 rst SHALL take priority over En and Clr, and over a clear sweep in progress. The sweep is abandoned.
REQ-016 The first write SHALL be accepted at the first edge with rst=0 and En=1.

Configuration
REQ-017 When DEMUX8_BYTE_MASK_EN is defined, the block SHALL add input BE (4 bits); an accepted write SHALL update only those bytes k of N[F] where BE[k]=1.
REQ-018 A write with BE=0 SHALL still be accepted and SHALL still pulse Ack, with data unchanged.
REQ-019 When DEMUX8_BYTE_MASK_EN is undefined, the BE port SHALL be absent and every write SHALL update the full word.
REQ-020 The clear sweep SHALL zero full words in both configurations.

Verification
REQ-021 Reset, then write D=0xDEADBEEF with F=5 and En=1 for one cycle -> next cycle N5=0xDEADBEEF, Ack=1 for 1 cycle, all other Nk=0.
REQ-022 Eight consecutive writes with F=0..7 and D=0x11111111*(F+1) -> Ack high 8 consecutive cycles, then each Nk=0x11111111*(k+1).
REQ-023 All Nk nonzero, Clr=1 and En=1 (F=2, D=0xA5A5A5A5) in the same cycle -> no Ack, Busy high 8 cycles, Nk zeroed in order 0..7, N2 ends 0.
REQ-024 Writes with En=1 during Busy -> no Ack, and no Nk takes the written data; a write issued after Busy falls is accepted.
REQ-025 Clr, then rst=1 on the 4th CLEAR cycle -> next cycle Busy=0, all Nk=0; the following write is accepted normally.
REQ-026 With DEMUX8_BYTE_MASK_EN defined: N3=0x12345678, then write D=0xFFFFFFFF with BE=4'b0101 -> N3=0x12FF56FF, Ack pulses.

Source files
------------

// File: rtl/demux8_reg.sv
// Registered 1-to-8 write demultiplexer with an eight-cycle clear sweep.
// Optional per-byte write enables are added when DEMUX8_BYTE_MASK_EN is defined.
module demux8_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] D,
    input  logic [2:0]       F,
    input  logic             En,
    input  logic             Clr,
`ifdef DEMUX8_BYTE_MASK_EN
    input  logic [3:0]       BE,
`endif
    output logic             Ack,
    output logic             Busy,
    output logic [WIDTH-1:0] N0,
    output logic [WIDTH-1:0] N1,
    output logic [WIDTH-1:0] N2,
    output logic [WIDTH-1:0] N3,
    output logic [WIDTH-1:0] N4,
    output logic [WIDTH-1:0] N5,
    output logic [WIDTH-1:0] N6,
    output logic [WIDTH-1:0] N7
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state_q;
    logic [2:0]       cnt_q;
    logic [WIDTH-1:0] n_q [8];
    logic             ack_q;
    logic             busy_q;
    logic [WIDTH-1:0] wr_word_d;

    // Word that an accepted write stores into the selected destination.
    always_comb begin
`ifdef DEMUX8_BYTE_MASK_EN
        wr_word_d = n_q[F];
        for (int b = 0; b < WIDTH / 8; b++) begin
            if (BE[b[1:0]]) begin
                wr_word_d[b*8 +: 8] = D[b*8 +: 8];
            end
        end
`else
        wr_word_d = D;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                n_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    // Clear request wins; a coincident write is dropped.
                    if (Clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= 3'd0;
                        busy_q  <= 1'b1;
                        ack_q   <= 1'b0;
                    end else if (En) begin
                        n_q[F] <= wr_word_d;
                        ack_q  <= 1'b1;
                    end else begin
                        ack_q  <= 1'b0;
                    end
                end
                CLEAR: begin
                    ack_q      <= 1'b0;
                    n_q[cnt_q] <= '0;
                    cnt_q      <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign Ack  = ack_q;
    assign Busy = busy_q;
    assign N0   = n_q[0];
    assign N1   = n_q[1];
    assign N2   = n_q[2];
    assign N3   = n_q[3];
    assign N4   = n_q[4];
    assign N5   = n_q[5];
    assign N6   = n_q[6];
    assign N7   = n_q[7];

endmodule

// File: tb/tb_demux8_reg.sv
// Scoreboard bench for demux8_reg: a queue-based reference model predicts Ack,
// Busy and N0..N7 after every edge; a negedge monitor pops and compares.
module tb_demux8_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] D;
    logic [2:0]  F;
    logic        En;
    logic        Clr;
    logic [3:0]  be;
    logic        Ack;
    logic        Busy;
    logic [31:0] N0, N1, N2, N3, N4, N5, N6, N7;

    always #5 clk = ~clk;

    demux8_reg #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .D    (D),
        .F    (F),
        .En   (En),
        .Clr  (Clr),
`ifdef DEMUX8_BYTE_MASK_EN
        .BE   (be),
`endif
        .Ack  (Ack),
        .Busy (Busy),
        .N0   (N0),
        .N1   (N1),
        .N2   (N2),
        .N3   (N3),
        .N4   (N4),
        .N5   (N5),
        .N6   (N6),
        .N7   (N7)
    );

    typedef struct packed {
        logic             ack;
        logic             busy;
        logic [7:0][31:0] n;
    } exp_t;

    exp_t             exp_q[$];
    logic [7:0][31:0] mem;
    int               clear_list[$];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: words in an array, a pending clear is a list of indices still to zero.
    task automatic model_edge(input logic r, input logic e, input logic c,
                              input logic [2:0] f, input logic [31:0] d, input logic [3:0] b);
        exp_t x;
        logic ack;
        ack = 1'b0;
        if (r) begin
            mem = '0;
            clear_list.delete();
        end else if (clear_list.size() > 0) begin
            mem[clear_list.pop_front()] = 32'h0;
        end else if (c) begin
            for (int k = 0; k < 8; k++) clear_list.push_back(k);
        end else if (e) begin
`ifdef DEMUX8_BYTE_MASK_EN
            for (int k = 0; k < 4; k++) begin
                if (b[k]) mem[f][k*8 +: 8] = d[k*8 +: 8];
            end
`else
            mem[f] = d;
`endif
            ack = 1'b1;
        end
        x.ack  = ack;
        x.busy = (clear_list.size() > 0);
        x.n    = mem;
        exp_q.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic e, input logic c,
                       input logic [2:0] f, input logic [31:0] d, input logic [3:0] b);
        rst = r; En = e; Clr = c; F = f; D = d; be = b;
        model_edge(r, e, c, f, d, b);
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 3'd0, 32'h0, 4'hF);
    endtask

    task automatic wr(input logic [2:0] f, input logic [31:0] d);
        cyc(1'b0, 1'b1, 1'b0, f, d, 4'hF);
    endtask

    initial begin : monitor
        exp_t x;
        logic [31:0] dn [8];
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                dn = '{N0, N1, N2, N3, N4, N5, N6, N7};
                chk("ack", {31'h0, Ack}, {31'h0, x.ack});
                chk("busy", {31'h0, Busy}, {31'h0, x.busy});
                for (int k = 0; k < 8; k++) chk($sformatf("N%0d", k), dn[k], x.n[k]);
            end
        end
    end

    initial begin : stim
        mem = '0;
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'hF);
        cyc(1'b1, 1'b1, 1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF);

        // Single write right after reset
        wr(3'd5, 32'hDEAD_BEEF);
        idle(2);

        // Back-to-back writes to every destination
        for (int k = 0; k < 8; k++) wr(k[2:0], 32'h1111_1111 * (k + 1));
        idle(1);

        // Clear with a coincident write, then writes while busy, then retry
        cyc(1'b0, 1'b1, 1'b1, 3'd2, 32'hA5A5_A5A5, 4'hF);
        for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, k[0], k[2:0], 32'hBAD0_0000 + k, 4'hF);
        wr(3'd3, 32'hCAFE_F00D);
        idle(2);

        // Reset on the fourth clear cycle abandons the sweep
        for (int k = 0; k < 8; k++) wr(k[2:0], 32'h0101_0101 * (k + 3));
        cyc(1'b0, 1'b0, 1'b1, 3'd0, 32'h0, 4'hF);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 4'hF);
        wr(3'd6, 32'h600D_600D);
        idle(2);

`ifdef DEMUX8_BYTE_MASK_EN
        wr(3'd3, 32'h1234_5678);
        cyc(1'b0, 1'b1, 1'b0, 3'd3, 32'hFFFF_FFFF, 4'b0101);
        cyc(1'b0, 1'b1, 1'b0, 3'd3, 32'h0000_0000, 4'b0000);
        idle(2);
`endif

        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 63) == 0),
                ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 24) == 0),
                3'($urandom_range(0, 7)),
                $urandom(),
                4'($urandom_range(0, 15)));
        end
        idle(12);

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
